fp29i_to_fp16_out: RTL and testbench



---
 rtl/fpalu_pkg.sv | 21 ++
 rtl/lzc22.sv | 17 +
 rtl/fp29i_to_fp16_out.sv | 159 +++++++++++++++
 tb/tb_fp29i_to_fp16_out.sv | 314 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fpalu_pkg.sv
// Shared FP ALU constants and types: FP29i/FP16 widths, biases and FP16 special values.
package fpalu_pkg;

  localparam int unsigned IN_EXP_W  = 6;
  localparam int unsigned IN_MAN_W  = 22;
  localparam int unsigned OUT_EXP_W = 5;
  localparam int unsigned OUT_MAN_W = 10;
  localparam int unsigned IN_BIAS   = 31;
  localparam int unsigned OUT_BIAS  = 15;
  localparam int unsigned REBIAS    = IN_BIAS - OUT_BIAS;

  localparam logic [15:0] FP16_POS_INF = 16'h7C00;
  localparam logic [15:0] FP16_MAX_FIN = 16'h7BFF;

  typedef struct packed {
    logic                sgn;
    logic [IN_EXP_W-1:0] exp;
    logic [IN_MAN_W-1:0] man;
  } fp29i_t;

endpackage

// File: rtl/lzc22.sv
// Combinational leading-zero counter for the 22-bit FP29i mantissa (returns 22 for zero).
module lzc22
  import fpalu_pkg::*;
(
  input  logic [IN_MAN_W-1:0] i_man,
  output logic [4:0]          o_lzc
);

  // Scanning upward lets the highest set bit win.
  always_comb begin
    o_lzc = 5'(IN_MAN_W);
    for (int i = 0; i < IN_MAN_W; i++) begin
      if (i_man[i]) o_lzc = 5'(IN_MAN_W - 1 - i);
    end
  end

endmodule

// File: rtl/fp29i_to_fp16_out.sv
// Two-stage FP29i -> IEEE FP16 output converter with RNE rounding and sticky flags.
// Define FP29I_TO_FP16_SAT_EN to saturate overflow to +/-max finite instead of +/-inf.
module fp29i_to_fp16_out
  import fpalu_pkg::*;
(
  input  logic                clk,
  input  logic                rst_n,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic                in_sgn,
  input  logic [IN_EXP_W-1:0] in_exp,
  input  logic [IN_MAN_W-1:0] in_man_dn,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [15:0]         out_fp16,
  output logic                out_inexact,
  input  logic                flag_clr,
  output logic                sticky_ovf,
  output logic                sticky_unf
);

`ifdef FP29I_TO_FP16_SAT_EN
  localparam logic [OUT_EXP_W+OUT_MAN_W-1:0] OVF_MAG = FP16_MAX_FIN[14:0];
`else
  localparam logic [OUT_EXP_W+OUT_MAN_W-1:0] OVF_MAG = FP16_POS_INF[14:0];
`endif

  fp29i_t              w_in;
  logic [4:0]          w_lzc;
  logic signed [7:0]   w_be;
  logic [IN_MAN_W-1:0] w_norm;
  logic                w_adv;
  logic                w_in_fire;
  logic                w_s2_load;

  logic                r_s1_valid;
  logic                r_s1_sgn;
  logic signed [7:0]   r_s1_be;
  logic [IN_MAN_W-1:0] r_s1_n;
  logic                r_s1_zero;

  logic                r_s2_valid;
  logic [15:0]         r_out_fp16;
  logic                r_out_inexact;
  logic                r_ovf;
  logic                r_unf;

  assign w_in = {in_sgn, in_exp, in_man_dn};

  lzc22 u_lzc (
    .i_man (w_in.man),
    .o_lzc (w_lzc)
  );

  assign w_be   = $signed({2'b00, w_in.exp}) - $signed(8'(REBIAS)) - $signed({3'b000, w_lzc});
  assign w_norm = w_in.man << w_lzc;

  assign w_adv     = !r_s2_valid || out_ready;
  assign in_ready  = !r_s1_valid || w_adv;
  assign w_in_fire = in_valid && in_ready;
  assign w_s2_load = w_adv && r_s1_valid;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s1_valid <= 1'b0;
      r_s1_sgn   <= 1'b0;
      r_s1_be    <= '0;
      r_s1_n     <= '0;
      r_s1_zero  <= 1'b0;
    end else begin
      if (in_ready) r_s1_valid <= in_valid;
      if (w_in_fire) begin
        r_s1_sgn  <= w_in.sgn;
        r_s1_be   <= w_be;
        r_s1_n    <= w_norm;
        r_s1_zero <= (w_in.man == '0);
      end
    end
  end

  // Stage 2: rounding and packing. Normals use shift 0, so one datapath serves both ranges.
  logic                w_sub;
  logic signed [7:0]   w_rsh;
  logic [4:0]          w_shamt;
  logic [44:0]         w_ext;
  logic [9:0]          w_frac;
  logic                w_guard;
  logic                w_sticky;
  logic                w_inc;
  logic                w_lost;
  logic [4:0]          w_exp_fld;
  logic [14:0]         w_sum;
  logic [15:0]         w_res;
  logic                w_res_inx;
  logic                w_ovf;
  logic                w_unf;

  always_comb begin
    w_sub = (r_s1_be <= 8'sd0);
    w_rsh = 8'sd1 - r_s1_be;
    if (!w_sub) begin
      w_shamt = 5'd0;
    end else if (w_rsh > 8'sd24) begin
      w_shamt = 5'd24;
    end else begin
      w_shamt = w_rsh[4:0];
    end
    // Bit 45 of the extended word is the hidden one; only bits below it are kept.
    w_ext     = 45'({r_s1_n, 24'b0} >> w_shamt);
    w_frac    = w_ext[44:35];
    w_guard   = w_ext[34];
    w_sticky  = |w_ext[33:0];
    w_inc     = w_guard && (w_sticky || w_frac[0]);
    w_lost    = w_guard || w_sticky;
    w_exp_fld = w_sub ? 5'd0 : r_s1_be[4:0];
    w_sum     = {w_exp_fld, w_frac} + {14'b0, w_inc};

    w_res     = {r_s1_sgn, w_sum};
    w_res_inx = w_lost;
    w_ovf     = 1'b0;
    w_unf     = 1'b0;
    if (r_s1_zero) begin
      w_res     = {r_s1_sgn, 15'b0};
      w_res_inx = 1'b0;
    end else if ((r_s1_be >= 8'sd31) || (w_sum[14:10] == 5'h1F)) begin
      w_res     = {r_s1_sgn, OVF_MAG};
      w_res_inx = 1'b1;
      w_ovf     = 1'b1;
    end else if (w_sub) begin
      w_unf = (w_sum == '0) || w_lost;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s2_valid    <= 1'b0;
      r_out_fp16    <= '0;
      r_out_inexact <= 1'b0;
      r_ovf         <= 1'b0;
      r_unf         <= 1'b0;
    end else begin
      if (w_adv) r_s2_valid <= r_s1_valid;
      if (w_s2_load) begin
        r_out_fp16    <= w_res;
        r_out_inexact <= w_res_inx;
      end
      // A set in the same cycle as a clear takes priority.
      r_ovf <= (r_ovf && !flag_clr) || (w_s2_load && w_ovf);
      r_unf <= (r_unf && !flag_clr) || (w_s2_load && w_unf);
    end
  end

  assign out_valid   = r_s2_valid;
  assign out_fp16    = r_out_fp16;
  assign out_inexact = r_out_inexact;
  assign sticky_ovf  = r_ovf;
  assign sticky_unf  = r_unf;

endmodule

// File: tb/tb_fp29i_to_fp16_out.sv
// Directed self-checking bench for fp29i_to_fp16_out.
module tb_fp29i_to_fp16_out;

`ifdef FP29I_TO_FP16_SAT_EN
  localparam logic [15:0] EXP_OVF = 16'h7BFF;
`else
  localparam logic [15:0] EXP_OVF = 16'h7C00;
`endif

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic        in_sgn;
  logic [5:0]  in_exp;
  logic [21:0] in_man_dn;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_fp16;
  logic        out_inexact;
  logic        flag_clr;
  logic        sticky_ovf;
  logic        sticky_unf;

  int n_tests;
  int n_fail;

  fp29i_to_fp16_out dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_sgn      (in_sgn),
    .in_exp      (in_exp),
    .in_man_dn   (in_man_dn),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_fp16    (out_fp16),
    .out_inexact (out_inexact),
    .flag_clr    (flag_clr),
    .sticky_ovf  (sticky_ovf),
    .sticky_unf  (sticky_unf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Sends one word with out_ready high; returns the result and cycles from accept to out_valid.
  task automatic run_one(input logic s, input logic [5:0] e, input logic [21:0] m,
                         output logic [15:0] f, output logic inx, output int lat);
    int n;
    @(negedge clk);
    out_ready = 1'b1;
    in_valid  = 1'b1;
    in_sgn    = s;
    in_exp    = e;
    in_man_dn = m;
    #1;
    n = 0;
    while (!in_ready && n < 20) begin
      @(negedge clk);
      #1;
      n++;
    end
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    f   = out_fp16;
    inx = out_inexact;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    n_tests++;
    if (out_valid !== 1'b0) begin n_fail++; $display("FAIL rst_out_valid: got %b exp 0", out_valid); end
    n_tests++;
    if (out_fp16 !== 16'h0000) begin n_fail++; $display("FAIL rst_out_fp16: got %h exp 0000", out_fp16); end
    n_tests++;
    if (out_inexact !== 1'b0) begin n_fail++; $display("FAIL rst_inexact: got %b exp 0", out_inexact); end
    n_tests++;
    if ({sticky_ovf, sticky_unf} !== 2'b00) begin
      n_fail++; $display("FAIL rst_sticky: got %b exp 00", {sticky_ovf, sticky_unf});
    end
    rst_n = 1'b1;
    @(negedge clk);
    n_tests++;
    if (in_ready !== 1'b1) begin n_fail++; $display("FAIL rst_in_ready: got %b exp 1", in_ready); end
  endtask

  task automatic test_basic();
    logic [15:0] f;
    logic        inx;
    int          lat;
    run_one(1'b0, 6'd31, 22'h200000, f, inx, lat);
    n_tests++;
    if (f !== 16'h3C00) begin n_fail++; $display("FAIL one_fp16: got %h exp 3c00", f); end
    n_tests++;
    if (inx !== 1'b0) begin n_fail++; $display("FAIL one_inexact: got %b exp 0", inx); end
    n_tests++;
    if (lat !== 2) begin n_fail++; $display("FAIL one_latency: got %0d exp 2", lat); end
    run_one(1'b0, 6'd31, 22'h100000, f, inx, lat);
    n_tests++;
    if (f !== 16'h3800) begin n_fail++; $display("FAIL half_fp16: got %h exp 3800", f); end
    run_one(1'b1, 6'd40, 22'h000000, f, inx, lat);
    n_tests++;
    if (f !== 16'h8000) begin n_fail++; $display("FAIL negzero_fp16: got %h exp 8000", f); end
    n_tests++;
    if (inx !== 1'b0) begin n_fail++; $display("FAIL negzero_inexact: got %b exp 0", inx); end
    run_one(1'b1, 6'd32, 22'h200000, f, inx, lat);
    n_tests++;
    if (f !== 16'hC000) begin n_fail++; $display("FAIL neg_two_fp16: got %h exp c000", f); end
  endtask

  task automatic test_rounding();
    logic [15:0] f;
    logic        inx;
    int          lat;
    run_one(1'b0, 6'd31, 22'h200400, f, inx, lat);
    n_tests++;
    if ({f, inx} !== {16'h3C00, 1'b1}) begin
      n_fail++; $display("FAIL rne_tie_even: got %h/%b exp 3c00/1", f, inx);
    end
    run_one(1'b0, 6'd31, 22'h200C00, f, inx, lat);
    n_tests++;
    if ({f, inx} !== {16'h3C02, 1'b1}) begin
      n_fail++; $display("FAIL rne_tie_odd: got %h/%b exp 3c02/1", f, inx);
    end
    run_one(1'b0, 6'd31, 22'h3FFFFF, f, inx, lat);
    n_tests++;
    if ({f, inx} !== {16'h4000, 1'b1}) begin
      n_fail++; $display("FAIL rne_carry_exp: got %h/%b exp 4000/1", f, inx);
    end
    run_one(1'b0, 6'd31, 22'h200401, f, inx, lat);
    n_tests++;
    if ({f, inx} !== {16'h3C01, 1'b1}) begin
      n_fail++; $display("FAIL rne_above_half: got %h/%b exp 3c01/1", f, inx);
    end
  endtask

  task automatic test_subnormal();
    logic [15:0] f;
    logic        inx;
    int          lat;
    run_one(1'b0, 6'd7, 22'h200000, f, inx, lat);
    n_tests++;
    if ({f, inx} !== {16'h0001, 1'b0}) begin
      n_fail++; $display("FAIL sub_min: got %h/%b exp 0001/0", f, inx);
    end
    n_tests++;
    if (sticky_unf !== 1'b0) begin n_fail++; $display("FAIL sub_exact_unf: got %b exp 0", sticky_unf); end
    run_one(1'b0, 6'd5, 22'h200000, f, inx, lat);
    n_tests++;
    if ({f, inx} !== {16'h0000, 1'b1}) begin
      n_fail++; $display("FAIL sub_flush: got %h/%b exp 0000/1", f, inx);
    end
    n_tests++;
    if (sticky_unf !== 1'b1) begin n_fail++; $display("FAIL sub_flush_unf: got %b exp 1", sticky_unf); end
    @(negedge clk);
    flag_clr = 1'b1;
    @(negedge clk);
    flag_clr = 1'b0;
    n_tests++;
    if (sticky_unf !== 1'b0) begin n_fail++; $display("FAIL unf_clear: got %b exp 0", sticky_unf); end
    run_one(1'b0, 6'd16, 22'h3FFFFF, f, inx, lat);
    n_tests++;
    if ({f, inx} !== {16'h0400, 1'b1}) begin
      n_fail++; $display("FAIL sub_round_to_normal: got %h/%b exp 0400/1", f, inx);
    end
    n_tests++;
    if (sticky_unf !== 1'b1) begin n_fail++; $display("FAIL sub_round_unf: got %b exp 1", sticky_unf); end
    n_tests++;
    if (sticky_ovf !== 1'b0) begin n_fail++; $display("FAIL sub_no_ovf: got %b exp 0", sticky_ovf); end
  endtask

  task automatic test_overflow();
    logic [15:0] f;
    logic        inx;
    int          lat;
    run_one(1'b0, 6'd47, 22'h200000, f, inx, lat);
    n_tests++;
    if ({f, inx} !== {EXP_OVF, 1'b1}) begin
      n_fail++; $display("FAIL ovf_word: got %h/%b exp %h/1", f, inx, EXP_OVF);
    end
    n_tests++;
    if (sticky_ovf !== 1'b1) begin n_fail++; $display("FAIL ovf_sticky: got %b exp 1", sticky_ovf); end
    @(negedge clk);
    flag_clr = 1'b1;
    @(negedge clk);
    flag_clr = 1'b0;
    n_tests++;
    if (sticky_ovf !== 1'b0) begin n_fail++; $display("FAIL ovf_clear: got %b exp 0", sticky_ovf); end
    // Rounding carry out of exponent 30, with a clear held across the set cycle.
    flag_clr = 1'b1;
    run_one(1'b1, 6'd46, 22'h3FFFFF, f, inx, lat);
    n_tests++;
    if (sticky_ovf !== 1'b1) begin n_fail++; $display("FAIL ovf_set_wins: got %b exp 1", sticky_ovf); end
    flag_clr = 1'b0;
    n_tests++;
    if (f !== {1'b1, EXP_OVF[14:0]}) begin
      n_fail++; $display("FAIL ovf_carry_word: got %h exp %h", f, {1'b1, EXP_OVF[14:0]});
    end
  endtask

  task automatic test_back_to_back();
    logic [5:0]  ve [4];
    logic        vs [4];
    logic [15:0] vx [4];
    logic [15:0] got [8];
    int          idx;
    int          ng;
    ve = '{6'd31, 6'd31, 6'd32, 6'd31};
    vs = '{1'b0, 1'b0, 1'b0, 1'b1};
    vx = '{16'h3C00, 16'h3800, 16'h4000, 16'hBC00};
    idx = 0;
    ng  = 0;
    for (int cyc = 0; cyc < 20; cyc++) begin
      @(negedge clk);
      out_ready = (cyc >= 3);
      in_valid  = (idx < 4);
      if (idx < 4) begin
        in_sgn    = vs[idx];
        in_exp    = ve[idx];
        in_man_dn = (idx == 1) ? 22'h100000 : 22'h200000;
      end
      #1;
      if (cyc == 2) begin
        n_tests++;
        if ({in_ready, 3'(idx)} !== {1'b0, 3'd2}) begin
          n_fail++; $display("FAIL stall_in_ready: got rdy=%b acc=%0d exp rdy=0 acc=2", in_ready, idx);
        end
        n_tests++;
        if ({out_valid, out_fp16} !== {1'b1, 16'h3C00}) begin
          n_fail++; $display("FAIL stall_hold: got %b/%h exp 1/3c00", out_valid, out_fp16);
        end
      end
      if (out_valid && out_ready) begin
        if (ng < 8) got[ng] = out_fp16;
        ng++;
      end
      if (in_valid && in_ready) idx++;
    end
    in_valid = 1'b0;
    n_tests++;
    if (ng !== 4) begin n_fail++; $display("FAIL b2b_count: got %0d exp 4", ng); end
    for (int i = 0; i < 4; i++) begin
      n_tests++;
      if (i >= ng || got[i] !== vx[i]) begin
        n_fail++; $display("FAIL b2b_word%0d: got %h exp %h", i, got[i], vx[i]);
      end
    end
  endtask

  task automatic test_reset_midstream();
    logic [15:0] f;
    logic        inx;
    int          lat;
    @(negedge clk);
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_sgn    = 1'b0;
    in_exp    = 6'd31;
    in_man_dn = 22'h200000;
    repeat (2) @(negedge clk);
    in_valid = 1'b0;
    #1;
    n_tests++;
    if (out_valid !== 1'b1) begin n_fail++; $display("FAIL mid_pre_valid: got %b exp 1", out_valid); end
    rst_n = 1'b0;
    #1;
    n_tests++;
    if (out_valid !== 1'b0) begin n_fail++; $display("FAIL mid_rst_valid: got %b exp 0", out_valid); end
    @(negedge clk);
    rst_n     = 1'b1;
    out_ready = 1'b1;
    repeat (3) @(negedge clk);
    n_tests++;
    if ({out_valid, in_ready} !== 2'b01) begin
      n_fail++; $display("FAIL mid_empty: got valid/rdy %b exp 01", {out_valid, in_ready});
    end
    run_one(1'b0, 6'd30, 22'h300000, f, inx, lat);
    n_tests++;
    if ({f, inx} !== {16'h3A00, 1'b0}) begin
      n_fail++; $display("FAIL mid_after: got %h/%b exp 3a00/0", f, inx);
    end
  endtask

  initial begin
    n_tests   = 0;
    n_fail    = 0;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_sgn    = 1'b0;
    in_exp    = '0;
    in_man_dn = '0;
    out_ready = 1'b1;
    flag_clr  = 1'b0;
    test_reset();
    test_basic();
    test_rounding();
    test_subnormal();
    test_overflow();
    test_back_to_back();
    test_reset_midstream();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
